memory_loader: RTL and testbench
================================

# memory_loader

Byte-stream loader that sits directly upstream of the 6502 system memory block and fills it before the CPU runs. Accepts framed bytes on a valid/ready stream (from the UART receiver), parses a start address and length header, and writes each payload byte to consecutive memory addresses through the single memory port. Holds the CPU off the memory port for the duration of a load and reports completion and checksum status.

## Interface
- DATA_WIDTH, 8, width of stream bytes and memory data; header parsing requires 8
- ADDR_WIDTH, 16, memory address width; header address and length fields are 16-bit

- clk  input  1  system clock, all logic rising-edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state
- in_data  input  DATA_WIDTH  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte; transfer occurs when in_valid & in_ready
- mem_en  output  1  memory port enable, drives memory rd_enable
- mem_we  output  1  memory write enable, drives memory wr_enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wr_data  output  DATA_WIDTH  memory write data
- cpu_hold  output  1  high while a frame is in progress; CPU must not drive memory
- done  output  1  one-cycle pulse at end of frame
- error  output  1  checksum mismatch; sticky until next sync byte accepted

## Operation
- Frame: SYNC (0xA5), ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, then CSUM byte (only with LOADER_CHECKSUM_EN).
- States: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM, FINISH.
- IDLE: accepted byte 0xA5 -> ADDR_LO, clears error, sets cpu_hold; any other byte discarded, stay IDLE.
- ADDR_LO/ADDR_HI/LEN_LO/LEN_HI: each accepted byte loads the field, advance one state.
- After LEN_HI: LEN==0 -> CSUM (macro on) or FINISH (macro off); else DATA with remaining count = LEN.
- DATA: each accepted byte issues one write at current address, address += 1 modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000), count -= 1, running sum += byte modulo 256; on last byte -> CSUM or FINISH.
- CSUM: accepted byte compared with running sum; mismatch sets error; -> FINISH. Memory already written is not rolled back.
- FINISH: done=1 for exactly this cycle, cpu_hold deasserts, -> IDLE. in_ready=0 in FINISH.
- in_ready=1 in every other state out of reset; 0 while reset asserted.
- mem_en and mem_we always equal (loader never reads).

## Timing
- Reset values: in_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wr_data=0, cpu_hold=0, done=0, error=0; state IDLE, sum=0.
- Write latency: payload accepted in cycle N -> mem_en=mem_we=1, mem_addr, mem_wr_data registered and valid in cycle N+1, for one cycle only. Back-to-back accepted bytes give back-to-back writes.
- cpu_hold rises cycle after SYNC accepted; falls cycle after FINISH (stays high through FINISH cycle and the final write).
- done asserted the cycle after the final byte (last payload or CSUM) is accepted; final write and done coincide when macro off.
- error changes the cycle after CSUM accepted; clears the cycle after next SYNC accepted.
- in_valid low mid-frame: state holds indefinitely, no timeout.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, partial frame abandoned; writes already performed remain.

## Configuration
- LOADER_CHECKSUM_EN defined: CSUM state present, trailer byte expected, error driven as above.
- Undefined: no CSUM state or sum register, frame ends after last payload byte, error tied 0.

## Test plan
- Frame A5 00 02 03 00 11 22 33 (+CSUM 66): writes 0x11@0x0200, 0x22@0x0201, 0x33@0x0202 on consecutive cycles, done one pulse, error=0.
- Wrong CSUM 0x67 for same frame: same three writes, done pulse, error=1, then new A5 clears error.
- Wrap: A5 FF FF 02 00 AA BB: writes 0xAA@0xFFFF, 0xBB@0x0000.
- Zero length: A5 34 12 00 00 (+CSUM 00): no mem_we, done pulse, error=0.
- Garbage 00 FF 5A before A5: discarded, cpu_hold stays 0 until A5 accepted; in_valid gaps mid-payload produce no extra writes.
- Reset low after 2 payload bytes of a 4-byte frame: outputs to reset values at once, later frame loads correctly.

Source files
------------

// File: rtl/memory_loader.sv
// Framed byte-stream loader: parses SYNC/address/length header and writes payload into system memory.
// Optional trailer checksum when LOADER_CHECKSUM_EN is defined; otherwise error is tied low.
module memory_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM, FINISH} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, FINISH} state_t;
`endif

    localparam logic [DATA_WIDTH-1:0] SYNC = 8'hA5;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] count;
    logic                  accept;

    assign accept = in_valid & in_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr        <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum         <= '0;
            error       <= 1'b0;
`endif
        end else begin
            // Write strobe and done are single-cycle pulses; in_ready drops only for the FINISH cycle
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && in_data == SYNC) begin
                        state    <= ADDR_LO;
                        cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        error    <= 1'b0;
                        sum      <= '0;
`endif
                    end
                end
                ADDR_LO: begin
                    if (accept) begin
                        addr[7:0] <= in_data;
                        state     <= ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (accept) begin
                        addr[15:8] <= in_data;
                        state      <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        count[7:0] <= in_data;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        if ({in_data, count[7:0]} == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= FINISH;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_en      <= 1'b1;
                        mem_we      <= 1'b1;
                        mem_addr    <= addr;
                        mem_wr_data <= in_data;
                        addr        <= addr + 1'b1;
                        count       <= count - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum         <= sum + in_data;
`endif
                        if (count == 1) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= FINISH;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        error    <= (in_data != sum);
                        state    <= FINISH;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
`endif
                FINISH: begin
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Scoreboard bench for memory_loader: stimulus pushes expected writes/done events, a monitor pops and compares.
module tb_memory_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    logic [23:0] wq[$];
    logic        dq[$];
    logic [7:0]  pl[$];

    memory_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_en || mem_we) begin
                chk("en_eq_we", {31'b0, mem_en}, {31'b0, mem_we});
                chk("hold_during_write", {31'b0, cpu_hold}, 32'd1);
                if (wq.size() == 0) fail_now("unexpected_write");
                else begin
                    logic [23:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", {16'b0, mem_addr}, {16'b0, e[23:8]});
                    chk("wr_data", {24'b0, mem_wr_data}, {24'b0, e[7:0]});
                end
            end
            if (done) begin
                chk("hold_at_done", {31'b0, cpu_hold}, 32'd1);
                if (dq.size() == 0) fail_now("unexpected_done");
                else begin
                    logic e;
                    e = dq.pop_front();
                    chk("error_at_done", {31'b0, error}, {31'b0, e});
                end
            end
        end
    end

    // Caller must be aligned to a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int   n;
        logic r;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        do begin
            r = in_ready;
            @(negedge clk);
            n++;
        end while (!r && n < 50);
        if (!r) fail_now("ready_timeout");
    endtask

    task automatic frame(input logic [15:0] addr, input logic [7:0] csum, input logic exp_err, input int gap);
        logic exp_e;
`ifdef LOADER_CHECKSUM_EN
        exp_e = exp_err;
`else
        exp_e = 1'b0;
`endif
        for (int i = 0; i < pl.size(); i++) begin
            logic [15:0] a;
            a = addr + 16'(i);
            wq.push_back({a, pl[i]});
        end
        dq.push_back(exp_e);
        send(8'hA5);
        chk("hold_after_sync", {31'b0, cpu_hold}, 32'd1);
        chk("error_cleared", {31'b0, error}, 32'd0);
        send(addr[7:0]);
        send(addr[15:8]);
        send(8'(pl.size()));
        send(8'(pl.size() >> 8));
        for (int i = 0; i < pl.size(); i++) begin
            send(pl[i]);
            if (gap > 0 && i == 1) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send(csum);
`endif
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("writes_drained", wq.size(), 32'd0);
        chk("done_seen", dq.size(), 32'd0);
        chk("hold_released", {31'b0, cpu_hold}, 32'd0);
        chk("error_sticky", {31'b0, error}, {31'b0, exp_e});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_outputs", {mem_en, mem_we, cpu_hold, done, error, mem_addr, mem_wr_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        pl = '{8'h11, 8'h22, 8'h33};
        frame(16'h0200, 8'h66, 1'b0, 0);
        frame(16'h0200, 8'h67, 1'b1, 0);

        pl = '{8'hAA, 8'hBB};
        frame(16'hFFFF, 8'h65, 1'b0, 0);

        pl = {};
        frame(16'h1234, 8'h00, 1'b0, 0);

        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        in_valid = 1'b0;
        @(negedge clk);
        chk("garbage_no_hold", {31'b0, cpu_hold}, 32'd0);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        frame(16'h1000, 8'h0A, 1'b0, 3);

        wq.push_back({16'h3000, 8'hDE});
        wq.push_back({16'h3001, 8'hAD});
        send(8'hA5);
        send(8'h00);
        send(8'h30);
        send(8'h04);
        send(8'h00);
        send(8'hDE);
        send(8'hAD);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_outputs", {mem_en, mem_we, cpu_hold, done, error, mem_addr, mem_wr_data}, 32'd0);
        chk("midrst_writes", wq.size(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        pl = '{8'h5A, 8'hC3};
        frame(16'h0300, 8'h1D, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
